// File: rtl/dm_bhw.sv
// dm_bhw: byte/halfword/word data memory for the MEM stage.
//
// Optional feature macro: DM_TRACE_EN
//   defined   -> every committed store prints "@pc: *wordaddr <= newword"
//   undefined -> no display statements are compiled
//
// Parameters:
//   ADDR_W  word-address bits, depth is 2**ADDR_W words
//   LAT     cycles from request acceptance to response (1..8)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (one outstanding request)
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata   byte address, right-justified store data
//   pc                    requesting PC, trace only
//   rsp_valid             one-cycle response pulse
//   rsp_rdata, rsp_err    load result (0 for stores/errors), reject flag
//   clr_busy              high while the post-reset clear sweep runs
//
// state | meaning
// CLEAR | sweep zeros through every word, one per cycle
// IDLE  | ready; accept a request, commit stores, capture load data
// BUSY  | wait-counter counts down; respond when it reaches 1
module dm_bhw #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        clr_busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} stateT;

  stateT              state;
  logic [ADDR_W-1:0]  clrCnt;
  logic [3:0]         waitCnt;
  logic [31:0]        pendData;
  logic               pendErr;

  logic [31:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  wordIdx;
  logic [31:0]        memRd;
  logic               reqErr;
  logic [7:0]         laneByte;
  logic [15:0]        laneHalf;
  logic [31:0]        loadWord;
  logic [31:0]        storeWord;
  logic               memWe;
  logic [ADDR_W-1:0]  memWaddr;
  logic [31:0]        memWdata;
  logic               unusedPc;

  assign unusedPc = ^pc;
  assign wordIdx  = req_addr[ADDR_W+1:2];
  assign memRd    = mem[wordIdx];
  assign laneByte = memRd[{req_addr[1:0], 3'b000} +: 8];
  assign laneHalf = memRd[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    reqErr = 1'b0;
    case (req_size)
      2'b00:   reqErr = 1'b0;
      2'b01:   reqErr = req_addr[0];
      2'b10:   reqErr = |req_addr[1:0];
      default: reqErr = 1'b1;
    endcase
    // Any address bit above the memory's byte range is out of bounds.
    if (|req_addr[31:ADDR_W+2]) reqErr = 1'b1;
  end

  always_comb begin
    loadWord = memRd;
    case (req_size)
      2'b00:   loadWord = {{24{~req_unsigned & laneByte[7]}}, laneByte};
      2'b01:   loadWord = {{16{~req_unsigned & laneHalf[15]}}, laneHalf};
      default: loadWord = memRd;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep their old value.
  always_comb begin
    storeWord = memRd;
    case (req_size)
      2'b00:   storeWord[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      2'b01:   storeWord[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      default: storeWord = req_wdata;
    endcase
  end

  always_comb begin
    memWe    = 1'b0;
    memWaddr = wordIdx;
    memWdata = storeWord;
    if (!reset) begin
      if (state == CLEAR) begin
        memWe    = 1'b1;
        memWaddr = clrCnt;
        memWdata = '0;
      end else if (state == IDLE && req_valid && req_we && !reqErr) begin
        memWe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memWaddr] <= memWdata;
`ifdef DM_TRACE_EN
    if (memWe && state == IDLE)
      $display("@%h: *%h <= %h", pc, {req_addr[31:2], 2'b00}, storeWord);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clrCnt    <= '0;
      waitCnt   <= '0;
      pendData  <= '0;
      pendErr   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      clr_busy  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        CLEAR: begin
          if (clrCnt == {ADDR_W{1'b1}}) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            clr_busy  <= 1'b0;
          end else begin
            clrCnt <= clrCnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (req_valid) begin
            state     <= BUSY;
            req_ready <= 1'b0;
            waitCnt   <= 4'(LAT);
            pendErr   <= reqErr;
            pendData  <= (reqErr || req_we) ? 32'h0 : loadWord;
          end
        end
        BUSY: begin
          if (waitCnt == 4'd1) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= pendData;
            rsp_err   <= pendErr;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_bhw.sv
module tb_dm_bhw;
  localparam int NI = 3;
  localparam int AWS[NI]  = '{4, 10, 4};
  localparam int LATS[NI] = '{1, 3, 4};

  logic        clk;
  logic        rst       [NI];
  logic        reqValid  [NI];
  logic        reqReady  [NI];
  logic        reqWe     [NI];
  logic [1:0]  reqSize   [NI];
  logic        reqUns    [NI];
  logic [31:0] reqAddr   [NI];
  logic [31:0] reqWdata  [NI];
  logic [31:0] pc;
  logic        rspValid  [NI];
  logic [31:0] rspRdata  [NI];
  logic        rspErr    [NI];
  logic        clrBusy   [NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : gDut
    dm_bhw #(.ADDR_W(AWS[g]), .LAT(LATS[g])) uDut (
      .clk          (clk),
      .reset        (rst[g]),
      .req_valid    (reqValid[g]),
      .req_ready    (reqReady[g]),
      .req_we       (reqWe[g]),
      .req_size     (reqSize[g]),
      .req_unsigned (reqUns[g]),
      .req_addr     (reqAddr[g]),
      .req_wdata    (reqWdata[g]),
      .pc           (pc),
      .rsp_valid    (rspValid[g]),
      .rsp_rdata    (rspRdata[g]),
      .rsp_err      (rspErr[g]),
      .clr_busy     (clrBusy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chkResetOut(input int i, input string tag);
    chk({tag, "_ready"}, 32'(reqReady[i]), 32'd0);
    chk({tag, "_valid"}, 32'(rspValid[i]), 32'd0);
    chk({tag, "_err"},   32'(rspErr[i]),   32'd0);
    chk({tag, "_rdata"}, rspRdata[i],      32'd0);
    chk({tag, "_busy"},  32'(clrBusy[i]),  32'd1);
  endtask

  // Starts on the negedge right after the reset edge.
  task automatic clrCount(input int i, input int expLen, input string tag);
    int n;
    bit busyOk;
    bit rspSeen;
    n = 0;
    busyOk = 1'b1;
    rspSeen = 1'b0;
    while (reqReady[i] !== 1'b1 && n < 2000) begin
      if (clrBusy[i] !== 1'b1) busyOk = 1'b0;
      if (rspValid[i] !== 1'b0) rspSeen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_len"},      32'(n),       32'(expLen));
    chk({tag, "_busy"},     32'(busyOk),  32'd1);
    chk({tag, "_norsp"},    32'(rspSeen), 32'd0);
    chk({tag, "_busy_end"}, 32'(clrBusy[i]), 32'd0);
  endtask

  task automatic xact(input int i, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] expData, input logic expErr, input string tag);
    int n;
    n = 0;
    while (reqReady[i] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 32'(reqReady[i]), 32'd1);
    reqValid[i] = 1'b1;
    reqWe[i]    = we;
    reqSize[i]  = sz;
    reqUns[i]   = uns;
    reqAddr[i]  = a;
    reqWdata[i] = wd;
    @(posedge clk);
    @(negedge clk);
    reqValid[i] = 1'b0;
    n = 0;
    while (rspValid[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"},  32'(n),          32'(LATS[i]));
    chk({tag, "_err"},  32'(rspErr[i]),  32'(expErr));
    chk({tag, "_data"}, rspRdata[i],     expData);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rspValid[i]), 32'd0);
  endtask

  initial begin
    int n;
    pc = '0;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; reqValid[i] = 1'b0; reqWe[i] = 1'b0; reqSize[i] = 2'b00;
      reqUns[i] = 1'b0; reqAddr[i] = '0; reqWdata[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chkResetOut(0, "rst0");
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    // Clear sweep on a 16-word instance
    clrCount(0, 16, "clr0");
    xact(0, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0, "clr_ld3c");

    // Byte lanes, LAT=1
    xact(0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h12345680, 32'h0, 1'b0, "sb5");
    xact(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h00008000, 1'b0, "lw4");
    xact(0, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFFFF80, 1'b0, "lb5");
    xact(0, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'h00000080, 1'b0, "lbu5");
    xact(0, 1'b1, 2'b00, 1'b0, 32'h7, 32'h0000007F, 32'h0, 1'b0, "sb7");
    xact(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h7F008000, 1'b0, "lw4b");
    xact(0, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h00007F00, 1'b0, "lh6");

    // Halfwords, LAT=3, 1024 words
    xact(1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 32'h0, 1'b0, "sw8");
    xact(1, 1'b1, 2'b01, 1'b0, 32'hA, 32'h5555BEEF, 32'h0, 1'b0, "shA");
    xact(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hBEEF3344, 1'b0, "lw8");
    xact(1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'hFFFFBEEF, 1'b0, "lhA");
    xact(1, 1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'h00003344, 1'b0, "lhu8");
    xact(1, 1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'hFFFFFFBE, 1'b0, "lbB");

    // Errors leave word 0 untouched and return zero data
    xact(1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, "sw0");
    xact(1, 1'b1, 2'b10, 1'b0, 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1, "e_sw2");
    xact(1, 1'b1, 2'b01, 1'b0, 32'h1, 32'h00001234, 32'h0, 1'b1, "e_sh1");
    xact(1, 1'b1, 2'b11, 1'b0, 32'h0, 32'h87654321, 32'h0, 1'b1, "e_sz3");
    xact(1, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEADDEAD, 32'h0, 1'b1, "e_oor");
    xact(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hBEEF3344, 1'b0, "lw8b");
    xact(1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, "e_lw2");
    xact(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "lw0");
    xact(1, 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0F0F0F0F, 32'h0, 1'b0, "swtop");
    xact(1, 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'h0F0F0F0F, 1'b0, "lwtop");

    // Reset in flight, LAT=4
    xact(2, 1'b1, 2'b10, 1'b0, 32'h14, 32'hA5A5A5A5, 32'h0, 1'b0, "sw14");
    xact(2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hA5A5A5A5, 1'b0, "lw14");
    n = 0;
    while (reqReady[2] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    reqValid[2] = 1'b1; reqWe[2] = 1'b1; reqSize[2] = 2'b10;
    reqAddr[2] = 32'h10; reqWdata[2] = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    reqValid[2] = 1'b0;
    chk("mid_busy_norsp", 32'(rspValid[2]), 32'd0);
    @(negedge clk);
    chk("mid_busy_norsp2", 32'(rspValid[2]), 32'd0);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    chkResetOut(2, "rst_mid");
    clrCount(2, 16, "clr_mid");
    xact(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "lw10_clr");
    xact(2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, "lw14_clr");

    // Trace store (prints only with DM_TRACE_EN)
    pc = 32'h00003000;
    xact(2, 1'b1, 2'b00, 1'b0, 32'h7, 32'h000000AB, 32'h0, 1'b0, "sb7_tr");
    pc = 32'h0;
    xact(2, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hAB000000, 1'b0, "lw4_tr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
